// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store access unit: the FSM
// state encoding, bus widths and the default legal data-address window.
package mem_access_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // Default legal data window, inclusive on both ends.
  localparam int DEFAULT_ADDR_LO = 64;
  localparam int DEFAULT_ADDR_HI = 127;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    LOAD_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

endpackage : mem_access_pkg

// File: rtl/mem_access_unit_if.sv
// Bundle of the request, response and data-memory signals of the access
// unit. The master side is the requester (which also plays the memory in
// the bench); the slave side is the access unit itself.
interface mem_access_unit_if;
  import mem_access_pkg::*;

  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;

  // Data memory port (read data is registered inside the memory)
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output req_valid, req_store, req_addr, req_wdata,
    output resp_ready,
    output mem_read_data,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write_data, mem_write_enable
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata,
    input  resp_ready,
    input  mem_read_data,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write_data, mem_write_enable
  );

endinterface : mem_access_unit_if

// File: rtl/mem_access_addr_check.sv
// Inclusive address-window comparator: in_range is high when
// ADDR_LO <= addr <= ADDR_HI. Purely combinational. Only instantiated by
// mem_access_unit when MEM_ACCESS_RANGE_CHECK_EN is defined.
module mem_access_addr_check
  import mem_access_pkg::*;
#(
  parameter int ADDR_LO = DEFAULT_ADDR_LO,
  parameter int ADDR_HI = DEFAULT_ADDR_HI
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  localparam logic [ADDR_W-1:0] LO_C = ADDR_W'(ADDR_LO);
  localparam logic [ADDR_W-1:0] HI_C = ADDR_W'(ADDR_HI);

  // Compare the request address against both window bounds
  always_comb begin
    in_range = 1'b0;
    if ((addr >= LO_C) && (addr <= HI_C)) begin
      in_range = 1'b1;
    end else begin
      in_range = 1'b0;
    end
  end

endmodule : mem_access_addr_check

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store access unit in front of a data memory with
// a one-cycle registered read.
//   store: accept -> ACCESS (one write strobe cycle) -> RESP
//   load : accept -> ACCESS (address presented) -> LOAD_WAIT (capture) -> RESP
// Optional feature macro: MEM_ACCESS_RANGE_CHECK_EN. When defined, requests
// outside [ADDR_LO, ADDR_HI] are answered straight from IDLE with a fault and
// never touch the memory port. When undefined, every address is forwarded and
// resp_fault stays 0.
// All outputs are driven directly from flops.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_LO = DEFAULT_ADDR_LO,
  parameter int ADDR_HI = DEFAULT_ADDR_HI
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  state_t            state_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic              resp_fault_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_write_data_r;
  logic              mem_write_enable_r;

  // reject_s: the incoming request must be answered with a fault instead
  // of being forwarded to memory.
  logic              reject_s;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  logic              in_range_s;

  mem_access_addr_check #(
    .ADDR_LO (ADDR_LO),
    .ADDR_HI (ADDR_HI)
  ) u_addr_check (
    .addr     (bus.req_addr),
    .in_range (in_range_s)
  );

  assign reject_s = ~in_range_s;
`else
  // Window bounds have no effect without the range check.
  localparam int unused_window_span = ADDR_HI - ADDR_LO;

  assign reject_s = 1'b0;
`endif

  // Transaction FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r            <= IDLE;
      req_ready_r        <= 1'b1;
      resp_valid_r       <= 1'b0;
      resp_rdata_r       <= '0;
      resp_fault_r       <= 1'b0;
      mem_address_r      <= '0;
      mem_write_data_r   <= '0;
      mem_write_enable_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            if (reject_s) begin
              // Out-of-window: answer immediately, memory port untouched.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= '0;
              resp_fault_r <= 1'b1;
            end else begin
              state_r            <= ACCESS;
              mem_address_r      <= bus.req_addr;
              mem_write_data_r   <= bus.req_wdata;
              mem_write_enable_r <= bus.req_store;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ACCESS: begin
          // The write strobe lives for this single cycle only.
          mem_write_enable_r <= 1'b0;
          if (mem_write_enable_r) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= '0;
            resp_fault_r <= 1'b0;
          end else begin
            // Memory registers the read on this edge; data valid next cycle.
            state_r <= LOAD_WAIT;
          end
        end

        LOAD_WAIT: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= bus.mem_read_data;
          resp_fault_r <= 1'b0;
        end

        RESP: begin
          // Response payload stays put until the consumer takes it.
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            state_r <= RESP;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean idle.
          state_r            <= IDLE;
          req_ready_r        <= 1'b1;
          resp_valid_r       <= 1'b0;
          mem_write_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_r;
  assign bus.resp_valid       = resp_valid_r;
  assign bus.resp_rdata       = resp_rdata_r;
  assign bus.resp_fault       = resp_fault_r;
  assign bus.mem_address      = mem_address_r;
  assign bus.mem_write_data   = mem_write_data_r;
  assign bus.mem_write_enable = mem_write_enable_r;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. A behavioural data
// memory with one-cycle registered read sits on the memory port. Expected
// responses are queued when a request is driven and popped when the unit
// presents its response.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  typedef struct packed {
    logic [7:0] rdata;
    logic       fault;
  } exp_t;

  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int we_count     = 0;
  int we_base      = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(
    .ADDR_LO (64),
    .ADDR_HI (127)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural data memory: write on strobe, registered read
  logic [7:0] mem_model [256];
  logic [7:0] rd_q;

  always @(posedge clk) begin
    if (bus.mem_write_enable) mem_model[bus.mem_address] <= bus.mem_write_data;
    rd_q <= mem_model[bus.mem_address];
  end

  assign bus.mem_read_data = rd_q;

  // Count cycles with the write strobe high
  always @(negedge clk) begin
    if (bus.mem_write_enable === 1'b1) we_count <= we_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request (called just after a negedge); it is accepted at the next posedge.
  task automatic issue(input string tag, input logic store, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rdata, input logic exp_fault);
    exp_t e;
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    sb.push_back(e);
    we_base       = we_count;
    bus.req_valid = 1'b1;
    bus.req_store = store;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
  endtask

  // Wait for the response, check latency/payload, optionally finish the handshake.
  task automatic collect(input string tag, input int exp_lat, input int exp_we, input bit do_hs);
    int   lat;
    exp_t e;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (lat < 0) return;
    check({tag, "_rdata"}, 32'(bus.resp_rdata), 32'(e.rdata));
    check({tag, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
    if (do_hs) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_resp_valid_drop"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_we_cycles"}, 32'(we_count - we_base), 32'(exp_we));
    end
  endtask

  initial begin
    int         we_snap;
    logic [7:0] addr_snap;

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_addr   = 8'd0;
    bus.req_wdata  = 8'd0;
    bus.resp_ready = 1'b1;

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("in_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_we", 32'(bus.mem_write_enable), 32'd0);
    check("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    check("rst_fault", 32'(bus.resp_fault), 32'd0);
    check("rst_mem_address", 32'(bus.mem_address), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_write_data), 32'd0);

    // Store then load at 70; first accept on first edge after release
    issue("st70", 1'b1, 8'd70, 8'hA5, 8'h00, 1'b0);
    collect("st70", 1, 1, 1'b1);
    issue("ld70", 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    collect("ld70", 2, 0, 1'b1);

    // Second data pattern
    issue("st100", 1'b1, 8'd100, 8'h5A, 8'h00, 1'b0);
    collect("st100", 1, 1, 1'b1);
    issue("ld100", 1'b0, 8'd100, 8'h00, 8'h5A, 1'b0);
    collect("ld100", 2, 0, 1'b1);

    // Lower window edge, then backpressured load from it
    issue("st64", 1'b1, 8'd64, 8'h3C, 8'h00, 1'b0);
    collect("st64", 1, 1, 1'b1);
    bus.resp_ready = 1'b0;
    issue("bp64", 1'b0, 8'd64, 8'h00, 8'h3C, 1'b0);
    collect("bp64", 2, 0, 1'b0);
    we_snap       = we_count;
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_addr  = 8'd70;
    bus.req_wdata = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_rdata", 32'(bus.resp_rdata), 32'h3C);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_mem_address", 32'(bus.mem_address), 32'd64);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    check("bp_ignored_store_we", 32'(we_count - we_snap), 32'd0);
    issue("ld70_after_bp", 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    collect("ld70_after_bp", 2, 0, 1'b1);

    // Upper window edge
    issue("st127", 1'b1, 8'd127, 8'hC3, 8'h00, 1'b0);
    collect("st127", 1, 1, 1'b1);
    issue("ld127", 1'b0, 8'd127, 8'h00, 8'hC3, 1'b0);
    collect("ld127", 2, 0, 1'b1);

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    addr_snap = bus.mem_address;
    issue("f128", 1'b1, 8'd128, 8'h11, 8'h00, 1'b1);
    collect("f128", 0, 0, 1'b1);
    check("f128_mem_address", 32'(bus.mem_address), 32'(addr_snap));
    issue("f63", 1'b0, 8'd63, 8'h00, 8'h00, 1'b1);
    collect("f63", 0, 0, 1'b1);
    check("f63_mem_address", 32'(bus.mem_address), 32'(addr_snap));
`else
    addr_snap = 8'd128;
    issue("st128", 1'b1, 8'd128, 8'h77, 8'h00, 1'b0);
    collect("st128", 1, 1, 1'b1);
    check("st128_mem_address", 32'(bus.mem_address), 32'(addr_snap));
    issue("ld128", 1'b0, 8'd128, 8'h00, 8'h77, 1'b0);
    collect("ld128", 2, 0, 1'b1);
`endif

    // Reset while in LOAD_WAIT: aborted with no response
    issue("rst_ld", 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_mem_address", 32'(bus.mem_address), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hold_resp_valid", 32'(bus.resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("midrst_release_resp_valid", 32'(bus.resp_valid), 32'd0);
    issue("ld70_after_rst", 1'b0, 8'd70, 8'h00, 8'hA5, 1'b0);
    collect("ld70_after_rst", 2, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_access_unit
